// File: rtl/nf_uart_pkg.sv
// nf_uart_pkg: shared UART types and line levels.
// Used by the transmitter now and the receiver later.
package nf_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_st_t;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

endpackage

// File: rtl/nf_sync_fifo.sv
// nf_sync_fifo: single-clock FIFO, W bits x DEPTH (power of 2).
// Ports: push/wdata, pop/rdata (show-ahead head), full, empty, count.
module nf_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int NW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [NW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [NW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    // full is taken from the registered count, so a push into a
    // full FIFO is refused even if a pop happens in the same cycle
    assign full    = (count_q == NW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr_q];
    assign count   = count_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + NW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - NW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/nf_uart_tx_param.sv
// nf_uart_tx_param: FIFO-buffered UART transmitter, DW data bits,
// optional parity, 1/2 stop bits. Ports: req/tx_data in, req_ack/ovf,
// full/empty/count, busy/tx_done status, uart_tx serial line.
module nf_uart_tx_param
    import nf_uart_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       tr_en,
    input  logic [CW-1:0]              comp,
    input  logic                       par_en,
    input  logic                       par_odd,
    input  logic                       stop2,
    input  logic [DW-1:0]              tx_data,
    input  logic                       req,
    output logic                       req_ack,
    output logic                       ovf,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy,
    output logic                       tx_done,
    output logic                       uart_tx
);

    localparam int BW = $clog2(DW);

    uart_tx_st_t   state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [DW-1:0] sh_q, sh_d;
    logic          par_en_q, par_en_d;
    logic          stop2_q, stop2_d;
    logic          par_bit_q, par_bit_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          ack_q, ovf_q;

    logic [DW-1:0] head;
    logic [CW-1:0] comp_m1;
    logic          bit_end;
    logic          can_start;
    logic          load;

    nf_sync_fifo #(
        .W     (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (req),
        .wdata  (tx_data),
        .pop    (load),
        .rdata  (head),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    // comp of 0 behaves as 1: every cycle is a bit boundary
    assign comp_m1   = (comp == '0) ? '0 : comp - CW'(1);
    assign bit_end   = (baud_q >= comp_m1);
    assign can_start = tr_en && !empty;

    always_comb begin
        state_d   = state_q;
        baud_d    = bit_end ? '0 : baud_q + CW'(1);
        bit_d     = bit_q;
        sh_d      = sh_q;
        par_en_d  = par_en_q;
        stop2_d   = stop2_q;
        par_bit_d = par_bit_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        load      = 1'b0;

        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                load   = can_start;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = sh_q[0];
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == BW'(DW - 1)) begin
                        bit_d = '0;
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = UART_IDLE_LVL;
                        end
                    end else begin
                        sh_d  = sh_q >> 1;
                        tx_d  = sh_q[1];
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = UART_IDLE_LVL;
                    bit_d   = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop2_q && bit_q == '0) begin
                        bit_d = BW'(1);
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                        tx_d    = UART_IDLE_LVL;
                        // chain straight into the next frame
                        load    = can_start;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = UART_IDLE_LVL;
            end
        endcase

        if (load) begin
            state_d   = START;
            tx_d      = UART_START_LVL;
            baud_d    = '0;
            bit_d     = '0;
            sh_d      = head;
            par_en_d  = par_en;
            stop2_d   = stop2;
            par_bit_d = (^head) ^ par_odd;
        end
    end

    assign busy_d = (state_d != IDLE);

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= UART_IDLE_LVL;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            par_en_q  <= par_en_d;
            stop2_q   <= stop2_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            ack_q     <= req && !full;
            ovf_q     <= req && full;
        end
    end

    assign req_ack = ack_q;
    assign ovf     = ovf_q;
    assign busy    = busy_q;
    assign tx_done = done_q;
    assign uart_tx = tx_q;

endmodule

// File: tb/tb_nf_uart_tx_param.sv
// tb_nf_uart_tx_param: directed bench for the UART transmitter,
// DW=8 main instance plus a DW=5 instance.
module tb_nf_uart_tx_param;

    logic        clk;
    logic        resetn;
    logic        tr_en;
    logic [15:0] comp;
    logic        par_en;
    logic        par_odd;
    logic        stop2;
    logic [7:0]  tx_data;
    logic        req;
    logic        req_ack;
    logic        ovf;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        busy;
    logic        tx_done;
    logic        uart_tx;

    logic [4:0]  d5_data;
    logic        d5_req;
    logic        d5_ack;
    logic        d5_ovf;
    logic        d5_full;
    logic        d5_empty;
    logic [2:0]  d5_count;
    logic        d5_busy;
    logic        d5_done;
    logic        d5_tx;

    int n_checks = 0;
    int n_fail   = 0;

    nf_uart_tx_param #(.DW(8), .DEPTH(4), .CW(16)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .tr_en   (tr_en),
        .comp    (comp),
        .par_en  (par_en),
        .par_odd (par_odd),
        .stop2   (stop2),
        .tx_data (tx_data),
        .req     (req),
        .req_ack (req_ack),
        .ovf     (ovf),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .busy    (busy),
        .tx_done (tx_done),
        .uart_tx (uart_tx)
    );

    nf_uart_tx_param #(.DW(5), .DEPTH(4), .CW(16)) dut5 (
        .clk     (clk),
        .resetn  (resetn),
        .tr_en   (tr_en),
        .comp    (comp),
        .par_en  (par_en),
        .par_odd (par_odd),
        .stop2   (stop2),
        .tx_data (d5_data),
        .req     (d5_req),
        .req_ack (d5_ack),
        .ovf     (d5_ovf),
        .full    (d5_full),
        .empty   (d5_empty),
        .count   (d5_count),
        .busy    (d5_busy),
        .tx_done (d5_done),
        .uart_tx (d5_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1ns after the edge that entered START.
    task automatic check_frame(input logic [7:0] d, input int c,
                               input bit pe, input bit pb,
                               input bit s2, input bit more);
        chk("start_bit", uart_tx, 0);
        chk("busy_start", busy, 1);
        if (c > 1) begin
            tick(c - 1);
            chk("start_hold", uart_tx, 0);
            tick(1);
        end else begin
            tick(1);
        end
        chk("data_bit0", uart_tx, d[0]);
        for (int i = 1; i < 8; i++) begin
            tick(c);
            chk("data_bit", uart_tx, d[i]);
        end
        if (pe) begin
            tick(c);
            chk("parity_bit", uart_tx, pb);
        end
        tick(c);
        chk("stop_bit", uart_tx, 1);
        if (s2) begin
            tick(c);
            chk("stop2_bit", uart_tx, 1);
            chk("stop2_nodone", tx_done, 0);
        end
        if (c > 1) begin
            tick(c - 1);
            chk("done_early", tx_done, 0);
            tick(1);
        end else begin
            tick(1);
        end
        chk("tx_done", tx_done, 1);
        chk("busy_after", busy, more);
        chk("line_after", uart_tx, !more);
    endtask

    logic [7:0] w [6];
    logic [4:0] e5;
    int acks;
    int ovfs;

    initial begin
        resetn  = 1'b1;
        tr_en   = 1'b0;
        comp    = 16'd0;
        par_en  = 1'b0;
        par_odd = 1'b0;
        stop2   = 1'b0;
        tx_data = 8'h00;
        req     = 1'b0;
        d5_data = 5'h00;
        d5_req  = 1'b0;
        w[0] = 8'h31; w[1] = 8'hC4; w[2] = 8'h5A;
        w[3] = 8'h0F; w[4] = 8'hEE; w[5] = 8'h77;

        tick(3);
        chk("rst_tx", uart_tx, 1);
        chk("rst_ack", req_ack, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", tx_done, 0);
        resetn = 1'b0;
        tick(1);

        // smoke: 0x48 at comp=434
        tr_en   = 1'b1;
        comp    = 16'd434;
        tx_data = 8'h48;
        req     = 1'b1;
        tick(1);
        chk("smoke_ack", req_ack, 1);
        chk("smoke_empty", empty, 0);
        chk("smoke_count", count, 1);
        chk("smoke_idle_tx", uart_tx, 1);
        chk("smoke_idle_busy", busy, 0);
        req = 1'b0;
        tick(1);
        chk("smoke_ack_off", req_ack, 0);
        chk("smoke_popped", count, 0);
        check_frame(8'h48, 434, 0, 0, 0, 0);
        chk("smoke_empty_end", empty, 1);

        // fill and overflow with the transmitter disabled
        tr_en = 1'b0;
        comp  = 16'd4;
        acks  = 0;
        ovfs  = 0;
        req   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tx_data = w[i];
            tick(1);
            acks += int'(req_ack);
            ovfs += int'(ovf);
        end
        req = 1'b0;
        chk("fill_acks", acks, 4);
        chk("fill_ovfs", ovfs, 2);
        chk("fill_count", count, 4);
        chk("fill_full", full, 1);
        tick(3);
        chk("fill_hold_busy", busy, 0);
        chk("fill_hold_tx", uart_tx, 1);
        chk("fill_hold_count", count, 4);
        tr_en = 1'b1;
        tick(1);
        chk("drain_count", count, 3);
        for (int f = 0; f < 4; f++) begin
            check_frame(w[f], 4, 0, 0, 0, f < 3);
        end
        chk("drain_empty", empty, 1);
        chk("drain_count0", count, 0);

        // parity, two stop bits: 0x07 has three ones
        comp    = 16'd2;
        par_en  = 1'b1;
        par_odd = 1'b0;
        stop2   = 1'b1;
        tx_data = 8'h07;
        req     = 1'b1;
        tick(1);
        req = 1'b0;
        tick(1);
        check_frame(8'h07, 2, 1, 1, 1, 0);
        par_odd = 1'b1;
        req     = 1'b1;
        tick(1);
        req = 1'b0;
        tick(1);
        check_frame(8'h07, 2, 1, 0, 1, 0);
        par_en  = 1'b0;
        par_odd = 1'b0;
        stop2   = 1'b0;

        // enable drop mid-frame with two words queued
        comp    = 16'd4;
        tx_data = 8'h3C;
        req     = 1'b1;
        tick(1);
        tx_data = 8'hA5;
        tick(1);
        req = 1'b0;
        chk("pushpop_count", count, 1);
        chk("en_start", uart_tx, 0);
        tick(8);
        tr_en = 1'b0;
        tick(31);
        chk("en_done_early", tx_done, 0);
        tick(1);
        chk("en_done", tx_done, 1);
        chk("en_busy", busy, 0);
        chk("en_line", uart_tx, 1);
        chk("en_count", count, 1);
        tick(20);
        chk("en_hold_line", uart_tx, 1);
        chk("en_hold_busy", busy, 0);
        chk("en_hold_count", count, 1);
        tr_en = 1'b1;
        tick(1);
        check_frame(8'hA5, 4, 0, 0, 0, 0);
        chk("en_empty", empty, 1);

        // reset in the middle of DATA with a word still queued
        tx_data = 8'h11;
        req     = 1'b1;
        tick(1);
        tx_data = 8'h22;
        tick(1);
        tx_data = 8'h33;
        tick(1);
        req = 1'b0;
        chk("pre_rst_count", count, 2);
        tick(10);
        chk("pre_rst_low", uart_tx, 0);
        #2;
        resetn = 1'b1;
        #1;
        chk("mid_rst_tx", uart_tx, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_ack", req_ack, 0);
        chk("mid_rst_ovf", ovf, 0);
        chk("mid_rst_done", tx_done, 0);
        #2;
        resetn = 1'b0;
        tick(1);
        chk("post_rst_tx", uart_tx, 1);
        chk("post_rst_busy", busy, 0);
        tx_data = 8'hC3;
        req     = 1'b1;
        tick(1);
        req = 1'b0;
        tick(1);
        check_frame(8'hC3, 4, 0, 0, 0, 0);

        // degenerate baud values
        comp    = 16'd0;
        tx_data = 8'h5A;
        req     = 1'b1;
        tick(1);
        req = 1'b0;
        tick(1);
        check_frame(8'h5A, 1, 0, 0, 0, 0);
        comp    = 16'd1;
        tx_data = 8'hA5;
        req     = 1'b1;
        tick(1);
        req = 1'b0;
        tick(1);
        check_frame(8'hA5, 1, 0, 0, 0, 0);

        // DW=5 build, 0x15 at one cycle per bit
        e5      = 5'h15;
        d5_data = e5;
        d5_req  = 1'b1;
        tick(1);
        chk("d5_ack", d5_ack, 1);
        d5_req = 1'b0;
        tick(1);
        chk("d5_start", d5_tx, 0);
        chk("d5_busy", d5_busy, 1);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("d5_bit", d5_tx, e5[i]);
        end
        tick(1);
        chk("d5_stop", d5_tx, 1);
        chk("d5_nodone", d5_done, 0);
        tick(1);
        chk("d5_done", d5_done, 1);
        chk("d5_idle", d5_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nf_uart_tx_param.md
# nf_uart_tx_param

Parametrised successor UART transmitter for the nanoFOX peripheral set.
- Adds a TX FIFO, compile-time data width, and run-time parity and stop-bit modes.
- The CPU-side UART controller pushes words with a req/req_ack handshake; the block serialises them LSB-first on `uart_tx`.
- Drop-in for the existing UART path when configured DW=8, no parity, 1 stop bit.

## Interface
- `DW`, 8, data bits per frame, legal 5..9
- `DEPTH`, 4, TX FIFO entries, power of 2, ≥2
- `CW`, 16, width of baud compare value
- `clk`  in  1  clock
- `resetn`  in  1  reset; asynchronous, active-high
- `tr_en`  in  1  transmitter enable
- `comp`  in  CW  clock cycles per bit
- `par_en`  in  1  parity bit enable
- `par_odd`  in  1  1 = odd parity, 0 = even
- `stop2`  in  1  1 = two stop bits, 0 = one
- `tx_data`  in  DW  word to enqueue
- `req`  in  1  enqueue request, sampled every posedge
- `req_ack`  out  1  one-cycle pulse: word accepted
- `ovf`  out  1  one-cycle pulse: req while full, word dropped
- `full`  out  1  FIFO full
- `empty`  out  1  FIFO empty
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy
- `busy`  out  1  frame in progress (FSM not IDLE)
- `tx_done`  out  1  one-cycle pulse at end of each frame
- `uart_tx`  out  1  serial line, idle high

## Operation
- Enqueue: `req`=1 at an edge with `full`=0 writes `tx_data` and registers `req_ack`=1 for the following cycle.
  - `req` held high for N cycles enqueues N words.
  - `req` with `full`=1 drops the word and pulses `ovf` instead of `req_ack`.
  - `full` is evaluated before a same-cycle pop, so a write to a full FIFO is rejected even when the FSM pops in that cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if `tr_en`=1 and `empty`=0, pop the head word into the shift register, latch `par_en`/`par_odd`/`stop2`, and go to START.
  - START: drive 0 for one bit period, then DATA.
  - DATA: drive DW bits, LSB first, one bit period each. Then PARITY if `par_en` is latched, else STOP.
  - PARITY: drive the XOR of the data bits (even parity); invert it when `par_odd`=1.
  - STOP: drive 1 for one or two bit periods. Pulse `tx_done`, then apply the IDLE pop rule immediately, so back-to-back frames have no extra idle cycle.
- Bit period = `comp` cycles; `comp`=0 is treated as 1.
  - The baud counter runs from 0 to comp−1 and restarts at each bit boundary.
  - `comp` is sampled live; software changes it only while `busy`=0.
- `tr_en` falling mid-frame: the current frame completes, then the FSM holds IDLE. The FIFO keeps its contents and still accepts writes.
- Config inputs changing mid-frame have no effect until the next frame starts.
- Frame length in cycles = (1 + DW + par_en + 1 + stop2) × max(comp,1).

## Timing
- Reset values: `uart_tx`=1, `req_ack`=0, `ovf`=0, `full`=0, `empty`=1, `count`=0, `busy`=0, `tx_done`=0; FSM in IDLE, FIFO pointers at 0.
- Reset mid-frame forces the line high asynchronously and discards FIFO contents.
- All outputs are registered.
- `req` sampled at edge k into an empty FIFO with the FSM idle:
  - `req_ack`=1 and `empty`=0 during cycle k..k+1.
  - At edge k+1 the FSM pops and enters START; `uart_tx`=0 from edge k+1.
- `count` updates the edge after a push or pop. A simultaneous push and pop leaves `count` unchanged.
- `busy` rises with the START entry. It falls on the edge the FSM enters IDLE, in the same cycle `tx_done` is high.
- Pointers are `$clog2(DEPTH)` bits wide and wrap modulo DEPTH. Full/empty are derived from `count`.

## Structure
- Package `nf_uart_pkg` holds:
  - the state enum `uart_tx_st_t`: IDLE, START, DATA, PARITY, STOP;
  - constants `UART_IDLE_LVL`=1 and `UART_START_LVL`=0.
- Sub-module `nf_sync_fifo`, parametrised on width and depth with push/pop/full/empty/count.
  - It is reusable by the future receiver.
- The FSM, baud counter, bit counter and shift register live in the top module.

## Test plan
- Single-word smoke test. Config DW=8, comp=434, no parity, 1 stop; send 0x48.
  - Expect one `req_ack` pulse and `uart_tx` low for 434 cycles.
  - Then bits 0,0,0,1,0,0,1,0, then high.
  - `tx_done` pulses 4340 cycles after START.
- FIFO fill and overflow. Config comp=4, DEPTH=4, `tr_en`=0; hold `req` for 6 cycles.
  - Expect 4 `req_ack` pulses, 2 `ovf` pulses, `count`=4, `full`=1.
  - Set `tr_en`=1: 4 frames back-to-back with no idle cycles; finally `empty`=1, `busy`=0.
- Parity and stop-bit mode. Send 0x07 with `par_en`=1, `par_odd`=0, `stop2`=1, comp=2.
  - Expect parity bit 1, then two stop bits, frame length 24 cycles.
  - Repeat with `par_odd`=1: parity bit 0.
- Enable drop mid-frame: deassert `tr_en` during DATA with 2 words queued.
  - Expect the current frame to finish, then the line stays high and `count`=1.
  - Reassert `tr_en`: the remaining word is sent.
- Reset mid-frame: assert `resetn` during DATA.
  - Expect `uart_tx`=1 immediately and all outputs at their reset values.
  - After release, a new word is sent correctly.
- Degenerate baud: comp=0 and comp=1 both give 1-cycle bits. A DW=5 build sends 0x15 as bits 1,0,1,0,1.
